// File: rtl/pitch_pkg.sv
// Shared types and helpers for the pitch tracker: FSM state encoding,
// sample-format check and the saturating height-target mapping.
package pitch_pkg;

   typedef enum logic [1:0] {
      CAPTURE,
      WAIT_FFT,
      SCAN,
      UPDATE
   } state_t;

   localparam int DEFAULT_N_BINS = 64;
   localparam int BIN_W = $clog2(DEFAULT_N_BINS);

   // A shifted sample must fit entirely inside one FFT word.
   function automatic bit sample_fits(input int sample_w, input int frac_shift, input int mag_w);
      return (sample_w + frac_shift) <= mag_w;
   endfunction

   // base + step*bin, clamped to the largest value a height_w-bit screen height can hold.
   function automatic int height_target(input int base, input int step, input int bin, input int height_w);
      longint t;
      longint lim;
      t   = longint'(base) + longint'(step) * longint'(bin);
      lim = (longint'(1) << height_w) - longint'(1);
      return (t > lim) ? int'(lim) : int'(t);
   endfunction

endpackage

// File: rtl/pitch_tracker_peak_scanner.sv
// Walks the FFT bin range one address per cycle and keeps the strongest bin;
// magnitudes return one cycle after their address, so compares trail by one.
module peak_scanner
   import pitch_pkg::*;
#(
   parameter int MIN_BIN = 1,
   parameter int MAX_BIN = 31,
   parameter int MAG_W   = 32,
   parameter int ADDR_W  = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [MAG_W-1:0]  bin_mag,
   output logic [ADDR_W-1:0] bin_addr,
   output logic              done,
   output logic [ADDR_W-1:0] peak_bin,
   output logic [MAG_W-1:0]  peak_mag
);

   localparam logic [ADDR_W-1:0] FIRST_BIN = ADDR_W'(MIN_BIN);
   localparam logic [ADDR_W-1:0] LAST_BIN  = ADDR_W'(MAX_BIN);

   logic              issuing;
   logic              cmp_valid;
   logic [ADDR_W-1:0] cmp_bin;
   logic              have_peak;

   // Strict > keeps the earliest (lowest) bin on ties; the first compare always loads.
   always_ff @(posedge clk) begin
      if (reset) begin
         bin_addr  <= FIRST_BIN;
         issuing   <= 1'b0;
         cmp_valid <= 1'b0;
         cmp_bin   <= FIRST_BIN;
         have_peak <= 1'b0;
         peak_bin  <= FIRST_BIN;
         peak_mag  <= '0;
      end else begin
         cmp_valid <= issuing;
         cmp_bin   <= bin_addr;
         if (start) begin
            bin_addr  <= FIRST_BIN;
            issuing   <= 1'b1;
            have_peak <= 1'b0;
         end else if (issuing) begin
            if (bin_addr == LAST_BIN) begin
               issuing  <= 1'b0;
               bin_addr <= FIRST_BIN;
            end else begin
               bin_addr <= bin_addr + 1'b1;
            end
         end
         if (cmp_valid && (!have_peak || (bin_mag > peak_mag))) begin
            peak_mag  <= bin_mag;
            peak_bin  <= cmp_bin;
            have_peak <= 1'b1;
         end
      end
   end

   assign done = cmp_valid && (cmp_bin == LAST_BIN);

endmodule

// File: rtl/pitch_tracker.sv
// Pitch-to-height tracker: decimates and frames mic samples for an external FFT,
// scans the returned spectrum for its peak and turns that into a smoothed height.
module pitch_tracker
   import pitch_pkg::*;
#(
   parameter int SAMPLE_W     = 12,
   parameter int MAG_W        = 32,
   parameter int FRAC_SHIFT   = 16,
   parameter int N_BINS       = 64,
   parameter int DECIM        = 50000,
   parameter int MIN_BIN      = 1,
   parameter int MAX_BIN      = 31,
   parameter int HEIGHT_W     = 10,
   parameter int HEIGHT_BASE  = 16,
   parameter int HEIGHT_STEP  = 7,
   parameter int SMOOTH_SHIFT = 2,
   parameter int FFT_TIMEOUT  = 4096,
   localparam int ADDR_W      = $clog2(N_BINS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic [SAMPLE_W-1:0] mic_data,
   input  logic [MAG_W-1:0]    mag_threshold,
   output logic                fft_start,
   output logic                fft_sample_valid,
   output logic [MAG_W-1:0]    fft_sample,
   input  logic                fft_done,
   output logic [ADDR_W-1:0]   fft_bin_addr,
   input  logic [MAG_W-1:0]    fft_bin_mag,
   output logic [HEIGHT_W-1:0] height,
   output logic                height_valid,
   output logic                voiced,
   output logic                fft_timeout
);

   localparam int DECIM_W = $clog2(DECIM);
   localparam int WAIT_W  = $clog2(FFT_TIMEOUT + 1);

   localparam logic [DECIM_W-1:0]  DECIM_LAST  = DECIM_W'(DECIM - 1);
   localparam logic [ADDR_W-1:0]   SAMPLE_LAST = ADDR_W'(N_BINS - 1);
   localparam logic [WAIT_W-1:0]   WAIT_LAST   = WAIT_W'(FFT_TIMEOUT - 1);
   localparam logic [HEIGHT_W-1:0] HEIGHT_INIT = HEIGHT_W'(HEIGHT_BASE);

   if (!sample_fits(SAMPLE_W, FRAC_SHIFT, MAG_W)) begin : g_bad_format
      $error("pitch_tracker: SAMPLE_W + FRAC_SHIFT exceeds MAG_W");
   end

   state_t state, next_state;

   logic [DECIM_W-1:0] decim_cnt;
   logic [ADDR_W-1:0]  sample_idx;
   logic [WAIT_W-1:0]  wait_cnt;

   logic               tick;
   logic               last_sample;
   logic               wait_expired;
   logic               scan_start;
   logic               scan_done;
   logic [ADDR_W-1:0]  peak_bin;
   logic [MAG_W-1:0]   peak_mag;

   logic                  is_voiced;
   logic [HEIGHT_W-1:0]   target;
   logic signed [HEIGHT_W:0] diff;
   logic signed [HEIGHT_W:0] delta;
   logic [MAG_W-1:0]      sample_ext;

   assign tick         = (state == CAPTURE) && enable && (decim_cnt == DECIM_LAST);
   assign last_sample  = (sample_idx == SAMPLE_LAST);
   assign wait_expired = (wait_cnt == WAIT_LAST);
   assign scan_start   = (state == WAIT_FFT) && fft_done;
   assign sample_ext   = MAG_W'(mic_data);

   peak_scanner #(
      .MIN_BIN (MIN_BIN),
      .MAX_BIN (MAX_BIN),
      .MAG_W   (MAG_W),
      .ADDR_W  (ADDR_W)
   ) u_scanner (
      .clk      (clk),
      .reset    (reset),
      .start    (scan_start),
      .bin_mag  (fft_bin_mag),
      .bin_addr (fft_bin_addr),
      .done     (scan_done),
      .peak_bin (peak_bin),
      .peak_mag (peak_mag)
   );

   // Height step: signed one-bit-wider difference so downward moves shift arithmetically.
   always_comb begin
      is_voiced = (peak_mag >= mag_threshold);
      target    = HEIGHT_W'(height_target(HEIGHT_BASE, HEIGHT_STEP, int'(peak_bin), HEIGHT_W));
      diff      = $signed({1'b0, target}) - $signed({1'b0, height});
      delta     = diff >>> SMOOTH_SHIFT;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= CAPTURE;
      end else begin
         state <= next_state;
      end
   end

   // fft_done is checked before the wait limit so a late-but-present result still counts.
   always_comb begin
      next_state = state;
      case (state)
         CAPTURE:  if (tick && last_sample) next_state = WAIT_FFT;
         WAIT_FFT: begin
            if (fft_done)          next_state = SCAN;
            else if (wait_expired) next_state = CAPTURE;
         end
         SCAN:     if (scan_done) next_state = UPDATE;
         UPDATE:   next_state = CAPTURE;
         default:  next_state = CAPTURE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         decim_cnt        <= '0;
         sample_idx       <= '0;
         wait_cnt         <= '0;
         fft_start        <= 1'b0;
         fft_sample_valid <= 1'b0;
         fft_sample       <= '0;
         height           <= HEIGHT_INIT;
         height_valid     <= 1'b0;
         voiced           <= 1'b0;
         fft_timeout      <= 1'b0;
      end else begin
         fft_start        <= 1'b0;
         fft_sample_valid <= 1'b0;
         height_valid     <= 1'b0;
         case (state)
            CAPTURE: begin
               wait_cnt <= '0;
               if (!enable) begin
                  decim_cnt  <= '0;
                  sample_idx <= '0;
               end else if (tick) begin
                  decim_cnt        <= '0;
                  fft_sample       <= sample_ext << FRAC_SHIFT;
                  fft_sample_valid <= 1'b1;
                  fft_start        <= (sample_idx == '0);
                  sample_idx       <= last_sample ? '0 : sample_idx + 1'b1;
               end else begin
                  decim_cnt <= decim_cnt + 1'b1;
               end
            end
            WAIT_FFT: begin
               if (!fft_done) begin
                  if (wait_expired) fft_timeout <= 1'b1;
                  else              wait_cnt    <= wait_cnt + 1'b1;
               end
            end
            UPDATE: begin
               voiced       <= is_voiced;
               height_valid <= 1'b1;
               if (is_voiced) height <= height + delta[HEIGHT_W-1:0];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pitch_tracker.sv
// Directed bench for pitch_tracker: two instances (no smoothing / SMOOTH_SHIFT=2)
// share stimulus and a registered FFT magnitude model.
module tb_pitch_tracker;

   localparam int SAMPLE_W    = 12;
   localparam int MAG_W       = 32;
   localparam int N_BINS      = 8;
   localparam int DECIM       = 4;
   localparam int MIN_BIN     = 1;
   localparam int MAX_BIN     = 7;
   localparam int HEIGHT_W    = 10;
   localparam int FFT_TIMEOUT = 32;
   localparam int ADDR_W      = 3;

   logic                clk = 1'b0;
   logic                reset;
   logic                enable;
   logic [SAMPLE_W-1:0] mic_data;
   logic [MAG_W-1:0]    mag_threshold;
   logic                fft_done;
   logic [MAG_W-1:0]    fft_bin_mag;
   logic [MAG_W-1:0]    mag_table [N_BINS];

   logic                start0, sv0, hv0, voiced0, to0;
   logic [MAG_W-1:0]    sample0;
   logic [ADDR_W-1:0]   addr0;
   logic [HEIGHT_W-1:0] height0;
   logic                start2, sv2, hv2, voiced2, to2;
   logic [MAG_W-1:0]    sample2;
   logic [ADDR_W-1:0]   addr2;
   logic [HEIGHT_W-1:0] height2;

   int total = 0;
   int bad   = 0;
   int cap_count;
   int hv_count;
   logic [MAG_W-1:0]    cap_sample [8];
   logic                cap_start  [8];
   int                  cap_time   [8];
   logic [HEIGHT_W-1:0] got_h0, got_h2;
   logic                got_v;

   always #5 clk = ~clk;

   always @(posedge clk) fft_bin_mag <= mag_table[addr0];

   pitch_tracker #(
      .SAMPLE_W(SAMPLE_W), .MAG_W(MAG_W), .FRAC_SHIFT(16), .N_BINS(N_BINS), .DECIM(DECIM),
      .MIN_BIN(MIN_BIN), .MAX_BIN(MAX_BIN), .HEIGHT_W(HEIGHT_W), .HEIGHT_BASE(16),
      .HEIGHT_STEP(7), .SMOOTH_SHIFT(0), .FFT_TIMEOUT(FFT_TIMEOUT)
   ) dut0 (
      .clk(clk), .reset(reset), .enable(enable), .mic_data(mic_data),
      .mag_threshold(mag_threshold), .fft_start(start0), .fft_sample_valid(sv0),
      .fft_sample(sample0), .fft_done(fft_done), .fft_bin_addr(addr0),
      .fft_bin_mag(fft_bin_mag), .height(height0), .height_valid(hv0),
      .voiced(voiced0), .fft_timeout(to0)
   );

   pitch_tracker #(
      .SAMPLE_W(SAMPLE_W), .MAG_W(MAG_W), .FRAC_SHIFT(16), .N_BINS(N_BINS), .DECIM(DECIM),
      .MIN_BIN(MIN_BIN), .MAX_BIN(MAX_BIN), .HEIGHT_W(HEIGHT_W), .HEIGHT_BASE(16),
      .HEIGHT_STEP(7), .SMOOTH_SHIFT(2), .FFT_TIMEOUT(FFT_TIMEOUT)
   ) dut2 (
      .clk(clk), .reset(reset), .enable(enable), .mic_data(mic_data),
      .mag_threshold(mag_threshold), .fft_start(start2), .fft_sample_valid(sv2),
      .fft_sample(sample2), .fft_done(fft_done), .fft_bin_addr(addr2),
      .fft_bin_mag(fft_bin_mag), .height(height2), .height_valid(hv2),
      .voiced(voiced2), .fft_timeout(to2)
   );

   task automatic set_mags(input logic [MAG_W-1:0] base, input int b1, input logic [MAG_W-1:0] v1,
                           input int b2, input logic [MAG_W-1:0] v2);
      for (int i = 0; i < N_BINS; i++) mag_table[i] = base;
      if (b1 >= 0) mag_table[b1] = v1;
      if (b2 >= 0) mag_table[b2] = v2;
   endtask

   task automatic apply_reset();
      reset    = 1'b1;
      enable   = 1'b0;
      fft_done = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic capture_frame(input int first_val);
      int n;
      n        = 0;
      mic_data = SAMPLE_W'(first_val);
      enable   = 1'b1;
      for (int c = 0; c < 48 && n < 8; c++) begin
         @(negedge clk);
         if (sv0) begin
            cap_sample[n] = sample0;
            cap_start[n]  = start0;
            cap_time[n]   = c;
            n++;
            mic_data = SAMPLE_W'(first_val + n);
         end
      end
      enable    = 1'b0;
      cap_count = n;
   endtask

   task automatic fire_done();
      fft_done = 1'b1;
      @(negedge clk);
      fft_done = 1'b0;
   endtask

   task automatic collect_update(input int window);
      hv_count = 0;
      for (int c = 0; c < window; c++) begin
         @(negedge clk);
         if (hv0) begin
            hv_count++;
            got_h0 = height0;
            got_h2 = height2;
            got_v  = voiced0;
         end
      end
   endtask

   task automatic run_frame(input int bin_hi, input int bin_hi2);
      set_mags(10, bin_hi, 100, bin_hi2, 100);
      capture_frame(1);
      fire_done();
      collect_update(20);
   endtask

   task automatic test_reset();
      total += 8;
      if (height0 !== 10'd16) begin bad++; $display("[TB] FAIL reset_height: got %0d expected 16", height0); end
      if (voiced0 !== 1'b0)   begin bad++; $display("[TB] FAIL reset_voiced: got %0d expected 0", voiced0); end
      if (hv0 !== 1'b0)       begin bad++; $display("[TB] FAIL reset_hv: got %0d expected 0", hv0); end
      if (start0 !== 1'b0)    begin bad++; $display("[TB] FAIL reset_start: got %0d expected 0", start0); end
      if (sv0 !== 1'b0)       begin bad++; $display("[TB] FAIL reset_sv: got %0d expected 0", sv0); end
      if (to0 !== 1'b0)       begin bad++; $display("[TB] FAIL reset_timeout: got %0d expected 0", to0); end
      if (sample0 !== '0)     begin bad++; $display("[TB] FAIL reset_sample: got %0d expected 0", sample0); end
      if (addr0 !== 3'd1)     begin bad++; $display("[TB] FAIL reset_addr: got %0d expected 1", addr0); end
   endtask

   task automatic test_capture_and_peak();
      int quiet;
      set_mags(10, 5, 100, -1, 0);
      capture_frame(1);
      total++;
      if (cap_count !== 8) begin bad++; $display("[TB] FAIL capture_count: got %0d expected 8", cap_count); end
      for (int k = 0; k < cap_count; k++) begin
         total += 3;
         if (cap_sample[k] !== MAG_W'((k + 1) << 16)) begin
            bad++; $display("[TB] FAIL capture_sample%0d: got %0h expected %0h", k, cap_sample[k], (k + 1) << 16);
         end
         if (cap_start[k] !== (k == 0)) begin
            bad++; $display("[TB] FAIL capture_start%0d: got %0d expected %0d", k, cap_start[k], k == 0);
         end
         if (cap_time[k] !== 3 + 4 * k) begin
            bad++; $display("[TB] FAIL capture_time%0d: got %0d expected %0d", k, cap_time[k], 3 + 4 * k);
         end
      end
      quiet = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (sv0) quiet++;
      end
      total++;
      if (quiet !== 0) begin bad++; $display("[TB] FAIL wait_no_samples: got %0d expected 0", quiet); end
      fire_done();
      collect_update(20);
      total += 4;
      if (hv_count !== 1) begin bad++; $display("[TB] FAIL peak_hv_pulses: got %0d expected 1", hv_count); end
      if (got_h0 !== 10'd51) begin bad++; $display("[TB] FAIL peak_height: got %0d expected 51", got_h0); end
      if (got_v !== 1'b1) begin bad++; $display("[TB] FAIL peak_voiced: got %0d expected 1", got_v); end
      if (got_h2 !== 10'd24) begin bad++; $display("[TB] FAIL peak_height_smooth: got %0d expected 24", got_h2); end
   endtask

   task automatic test_tie();
      run_frame(3, 6);
      total += 3;
      if (hv_count !== 1) begin bad++; $display("[TB] FAIL tie_hv_pulses: got %0d expected 1", hv_count); end
      if (got_h0 !== 10'd37) begin bad++; $display("[TB] FAIL tie_height: got %0d expected 37", got_h0); end
      if (got_h2 !== 10'd27) begin bad++; $display("[TB] FAIL tie_height_smooth: got %0d expected 27", got_h2); end
   endtask

   task automatic test_unvoiced();
      run_frame(-1, -1);
      total += 4;
      if (hv_count !== 1) begin bad++; $display("[TB] FAIL unvoiced_hv_pulses: got %0d expected 1", hv_count); end
      if (got_v !== 1'b0) begin bad++; $display("[TB] FAIL unvoiced_voiced: got %0d expected 0", got_v); end
      if (got_h0 !== 10'd37) begin bad++; $display("[TB] FAIL unvoiced_height: got %0d expected 37", got_h0); end
      if (got_h2 !== 10'd27) begin bad++; $display("[TB] FAIL unvoiced_height_smooth: got %0d expected 27", got_h2); end
   endtask

   task automatic test_scan_range();
      set_mags(10, 0, 1000, 7, 200);
      capture_frame(1);
      fire_done();
      collect_update(20);
      total += 3;
      if (hv_count !== 1) begin bad++; $display("[TB] FAIL range_hv_pulses: got %0d expected 1", hv_count); end
      if (got_h0 !== 10'd65) begin bad++; $display("[TB] FAIL range_height: got %0d expected 65", got_h0); end
      if (got_h2 !== 10'd36) begin bad++; $display("[TB] FAIL range_height_smooth: got %0d expected 36", got_h2); end
   endtask

   task automatic test_smoothing();
      logic [HEIGHT_W-1:0] exp_h2 [3];
      exp_h2[0] = 10'd24;
      exp_h2[1] = 10'd30;
      exp_h2[2] = 10'd35;
      apply_reset();
      for (int f = 0; f < 3; f++) begin
         run_frame(5, -1);
         total += 2;
         if (got_h2 !== exp_h2[f]) begin
            bad++; $display("[TB] FAIL smooth_frame%0d: got %0d expected %0d", f, got_h2, exp_h2[f]);
         end
         if (got_h0 !== 10'd51) begin
            bad++; $display("[TB] FAIL smooth_direct%0d: got %0d expected 51", f, got_h0);
         end
      end
   endtask

   task automatic test_timeout();
      int waited;
      set_mags(10, 5, 100, -1, 0);
      capture_frame(1);
      hv_count = 0;
      waited   = 0;
      while (!to0 && waited < 40) begin
         @(negedge clk);
         if (hv0) hv_count++;
         waited++;
      end
      total += 4;
      if (to0 !== 1'b1) begin bad++; $display("[TB] FAIL timeout_flag: got %0d expected 1", to0); end
      if (hv_count !== 0) begin bad++; $display("[TB] FAIL timeout_hv: got %0d expected 0", hv_count); end
      if (height0 !== 10'd51) begin bad++; $display("[TB] FAIL timeout_height: got %0d expected 51", height0); end
      if (height2 !== 10'd35) begin bad++; $display("[TB] FAIL timeout_height_smooth: got %0d expected 35", height2); end
      run_frame(5, -1);
      total += 4;
      if (cap_count !== 8) begin bad++; $display("[TB] FAIL after_timeout_count: got %0d expected 8", cap_count); end
      if (hv_count !== 1) begin bad++; $display("[TB] FAIL after_timeout_hv: got %0d expected 1", hv_count); end
      if (got_h2 !== 10'd39) begin bad++; $display("[TB] FAIL after_timeout_height: got %0d expected 39", got_h2); end
      if (to0 !== 1'b1) begin bad++; $display("[TB] FAIL timeout_sticky: got %0d expected 1", to0); end
   endtask

   task automatic test_reset_mid_scan();
      set_mags(10, 3, 100, -1, 0);
      capture_frame(1);
      fire_done();
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      total += 6;
      if (height0 !== 10'd16) begin bad++; $display("[TB] FAIL midscan_height: got %0d expected 16", height0); end
      if (height2 !== 10'd16) begin bad++; $display("[TB] FAIL midscan_height_smooth: got %0d expected 16", height2); end
      if (to0 !== 1'b0) begin bad++; $display("[TB] FAIL midscan_timeout: got %0d expected 0", to0); end
      if (voiced0 !== 1'b0) begin bad++; $display("[TB] FAIL midscan_voiced: got %0d expected 0", voiced0); end
      if (addr0 !== 3'd1) begin bad++; $display("[TB] FAIL midscan_addr: got %0d expected 1", addr0); end
      if (sample0 !== '0) begin bad++; $display("[TB] FAIL midscan_sample: got %0d expected 0", sample0); end
      reset = 1'b0;
      collect_update(20);
      total++;
      if (hv_count !== 0) begin bad++; $display("[TB] FAIL midscan_no_update: got %0d expected 0", hv_count); end
   endtask

   initial begin
      mic_data      = '0;
      mag_threshold = 32'd50;
      set_mags(10, -1, 0, -1, 0);
      apply_reset();
      test_reset();
      test_capture_and_peak();
      test_tie();
      test_unvoiced();
      test_scan_range();
      test_smoothing();
      test_timeout();
      test_reset_mid_scan();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pitch_tracker.md
# pitch_tracker

Parametrised pitch-to-height tracker for the pitch game. Decimates the microphone stream, frames it into N-sample blocks, streams each block to an external FFT core, then serially scans the returned bin magnitudes for the peak. The peak is mapped to a smoothed, saturated screen height, with voiced/unvoiced gating and FFT-timeout recovery.

## Interface
- SAMPLE_W, 12: mic sample width, unsigned.
- MAG_W, 32: FFT sample and magnitude word width.
- FRAC_SHIFT, 16: left shift that places a sample into the MAG_W word; requires SAMPLE_W+FRAC_SHIFT ≤ MAG_W.
- N_BINS, 64: frame length and FFT size; power of 2, ≥ 4.
- DECIM, 50000: clk cycles per captured sample; ≥ 2.
- MIN_BIN, 1 / MAX_BIN, 31: inclusive scan range; 0 ≤ MIN_BIN ≤ MAX_BIN < N_BINS.
- HEIGHT_W, 10; HEIGHT_BASE, 16; HEIGHT_STEP, 7: target = HEIGHT_BASE + HEIGHT_STEP·bin.
- SMOOTH_SHIFT, 2: smoothing shift; 0 = no smoothing.
- FFT_TIMEOUT, 4096: maximum wait cycles for fft_done.

Ports (clock and reset first):
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  capture enable.
- mic_data  in  SAMPLE_W  live mic sample.
- mag_threshold  in  MAG_W  minimum peak magnitude to count as voiced.
- fft_start  out  1  one-cycle pulse on the first sample of a frame.
- fft_sample_valid  out  1  one-cycle pulse per sample.
- fft_sample  out  MAG_W  zero-extended mic_data << FRAC_SHIFT.
- fft_done  in  1  pulse: all bins are readable.
- fft_bin_addr  out  log2(N_BINS)  bin read address.
- fft_bin_mag  in  MAG_W  magnitude at the address issued one cycle earlier.
- height  out  HEIGHT_W  smoothed height.
- height_valid  out  1  one-cycle pulse when height/voiced update.
- voiced  out  1  last frame peak ≥ mag_threshold.
- fft_timeout  out  1  sticky error flag; cleared only by reset.

## Operation
- States: CAPTURE → WAIT_FFT → SCAN → UPDATE → CAPTURE.
- CAPTURE:
  - The decimation counter runs 0..DECIM-1. A tick occurs when it reaches DECIM-1, then it wraps to 0.
  - On each tick, drive fft_sample from mic_data and pulse fft_sample_valid. fft_start is also asserted on sample 0.
  - After sample N_BINS-1, go to WAIT_FFT.
- enable low in CAPTURE: hold the counter and sample index at 0 and emit nothing. The partial frame is discarded; the next frame restarts at sample 0 with fft_start. enable is ignored in the other states.
- WAIT_FFT:
  - fft_done → SCAN.
  - Wait counter reaches FFT_TIMEOUT-1 → set fft_timeout and go to CAPTURE. height/voiced are unchanged and height_valid is not pulsed.
  - fft_done in CAPTURE, SCAN or UPDATE is ignored.
- SCAN:
  - Issue addresses MIN_BIN..MAX_BIN, one per cycle; each magnitude is compared on the following cycle.
  - Strict > comparison, so on a tie the lowest bin wins. The first compared bin initialises the maximum.
- UPDATE, one cycle:
  - voiced = peak_mag ≥ mag_threshold.
  - If voiced: target = HEIGHT_BASE + HEIGHT_STEP·peak_bin, computed at HEIGHT_W+log2(N_BINS)+4 bits and saturated to 2^HEIGHT_W−1. Then height += (target − height) >>> SMOOTH_SHIFT, using a signed HEIGHT_W+1 difference with an arithmetic shift.
  - If unvoiced: height holds.
  - Pulse height_valid, then return to CAPTURE.
- Samples arriving during WAIT_FFT, SCAN or UPDATE are not captured. The decimation counter restarts at 0 on re-entering CAPTURE.

## Timing
- Reset values:
  - state = CAPTURE; all counters = 0.
  - height = HEIGHT_BASE.
  - voiced, height_valid, fft_start, fft_sample_valid, fft_timeout = 0.
  - fft_sample = 0; fft_bin_addr = MIN_BIN.
- Reset mid-frame or mid-scan aborts immediately; no partial update occurs.
- First tick: DECIM cycles after entering CAPTURE. A frame spans N_BINS·DECIM cycles.
- All outputs are registered. fft_sample is captured from mic_data on the tick cycle and is valid in the cycle fft_sample_valid is high.
- SCAN lasts (MAX_BIN−MIN_BIN+1)+1 cycles. UPDATE follows.
- height_valid rises the cycle after the last compare, together with the new height/voiced values.
- fft_done and fft_timeout condition in the same cycle: fft_done wins.

## Structure
- Shared package pitch_pkg holds:
  - the state enum (CAPTURE, WAIT_FFT, SCAN, UPDATE);
  - localparams BIN_W = $clog2(N_BINS) and the sample-format width check;
  - the saturating height-target function.
- Sub-module peak_scanner covers the address sequencing, 1-cycle-latency compare, and peak bin/magnitude registers. It has start/done handshakes and is parametrised by MIN_BIN, MAX_BIN and MAG_W.

## Test plan
- DECIM=4, N_BINS=8, mic_data ramp 1,2,3… → fft_sample_valid every 4 cycles, fft_start on the first only. fft_sample = value<<16; 8 samples, then WAIT_FFT.
- Model returns magnitude 100 at bin 5 and 10 elsewhere; threshold 50, SMOOTH_SHIFT=0 → height = 16+35 = 51, voiced=1, height_valid single pulse.
- Equal magnitudes 100 at bins 3 and 6 → peak_bin 3, height 37.
- All magnitudes 10, threshold 50 → voiced=0, height holds the previous value, height_valid still pulses.
- SMOOTH_SHIFT=2, height 16, target 51 → successive frames give 24, 30, 35 (floor of diff>>2).
- fft_done withheld FFT_TIMEOUT cycles → fft_timeout=1 sticky, no height_valid, next frame captures normally. Reset asserted mid-SCAN → all outputs return to reset values.
